lfsr_checker: RTL and testbench



---
 rtl/lfsr_pkg.sv | 42 ++++
 rtl/lfsr_checker.sv | 171 +++++++++++++++++
 tb/tb_lfsr_checker.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/lfsr_pkg.sv
// -----------------------------------------------------------------------------
// lfsr_pkg
// Shared definitions for the LFSR word generator and its receive-side checker.
//   - checker FSM state encodings
//   - default feedback masks per word width
//   - lfsr_step: the single next-word function both ends use, so generator and
//     checker can never drift apart.
// -----------------------------------------------------------------------------
package lfsr_pkg;

   // Widest word lfsr_step handles; callers zero-extend and truncate around it.
   localparam int LFSR_MAXW = 32;

   // Checker FSM states.
   localparam logic [1:0] ST_HUNT   = 2'd0;
   localparam logic [1:0] ST_VERIFY = 2'd1;
   localparam logic [1:0] ST_LOCKED = 2'd2;

   // Maximal-length feedback masks for step(s) = {s[n-2:0], ^(s & TAPS)}.
   localparam logic [2:0] TAPS_3 = 3'b101;   // period 7
   localparam logic [3:0] TAPS_4 = 4'b1001;  // x^4+x+1, period 15

   // One LFSR step for an n-bit word held in the low bits of s: shift left and
   // feed the XOR of the tapped bits into the LSB. Bits above n are returned 0.
   // The all-zero word maps to itself (lock-up state).
   function automatic logic [LFSR_MAXW-1:0] lfsr_step(
      input logic [LFSR_MAXW-1:0] s,
      input logic [LFSR_MAXW-1:0] taps,
      input int                   n
   );
      logic [LFSR_MAXW-1:0] mask;
      logic                 fb;
      if (n >= LFSR_MAXW) begin
         mask = {LFSR_MAXW{1'b1}};
      end else begin
         mask = (32'd1 << n) - 32'd1;
      end
      fb = ^(s & taps & mask);
      return ((s << 1) | {{(LFSR_MAXW-1){1'b0}}, fb}) & mask;
   endfunction

endpackage

// File: rtl/lfsr_checker.sv
// -----------------------------------------------------------------------------
// lfsr_checker
// Receive-side checker for the LFSR_n word stream. Seeds a local copy of the
// generator LFSR from the incoming words, verifies LOCK_CNT consecutive
// predictions before declaring lock, then flywheels the prediction and counts
// mismatching words. LOSS_CNT consecutive mismatches while locked drop lock.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous reset, active-high
//   ena        in   data-valid qualifier for data_in
//   data_in    in   received n-bit LFSR word
//   clr_cnt    in   synchronous clear of err_cnt (wins over an increment)
//   locked     out  registered: checker is synchronised to the stream
//   err_pulse  out  one-cycle flag: last sampled word mismatched while locked
//   err_cnt    out  saturating count of mismatched words while locked
// -----------------------------------------------------------------------------
module lfsr_checker
   import lfsr_pkg::*;
#(
   parameter int         n        = 4,
   parameter logic [n-1:0] TAPS   = TAPS_4,
   parameter int         LOCK_CNT = 4,
   parameter int         LOSS_CNT = 3,
   parameter int         CW       = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          ena,
   input  logic [n-1:0]  data_in,
   input  logic          clr_cnt,
   output logic          locked,
   output logic          err_pulse,
   output logic [CW-1:0] err_cnt
);

   localparam int GW = $clog2(LOCK_CNT + 1);
   localparam int BW = $clog2(LOSS_CNT + 1);

   logic [1:0]    state_q,     state_d;
   logic [n-1:0]  exp_q,       exp_d;
   logic [GW-1:0] good_q,      good_d;
   logic [BW-1:0] bad_q,       bad_d;
   logic [CW-1:0] err_cnt_q,   err_cnt_d;
   logic          err_pulse_q, err_pulse_d;
   logic          locked_q,    locked_d;

   logic          match_s;
   logic          zero_s;
   logic          err_inc_s;
   logic [n-1:0]  step_data_s;
   logic [n-1:0]  step_exp_s;
   logic [GW-1:0] good_inc_s;
   logic [BW-1:0] bad_inc_s;

   // Next-word predictions from the received word (reseed) and from the
   // current prediction (flywheel).
   always_comb begin
      step_data_s = n'(lfsr_step(LFSR_MAXW'(data_in), LFSR_MAXW'(TAPS), n));
      step_exp_s  = n'(lfsr_step(LFSR_MAXW'(exp_q),   LFSR_MAXW'(TAPS), n));
      match_s     = (data_in == exp_q);
      zero_s      = (data_in == {n{1'b0}});
      good_inc_s  = good_q + GW'(1);
      bad_inc_s   = bad_q + BW'(1);
   end

   // Sync FSM: hunt for a non-zero seed, verify predictions, then flywheel.
   always_comb begin
      state_d     = state_q;
      exp_d       = exp_q;
      good_d      = good_q;
      bad_d       = bad_q;
      err_pulse_d = 1'b0;
      err_inc_s   = 1'b0;
      if (ena) begin
         case (state_q)
            ST_HUNT: begin
               if (!zero_s) begin
                  exp_d   = step_data_s;
                  good_d  = {GW{1'b0}};
                  state_d = ST_VERIFY;
               end else begin
                  state_d = ST_HUNT;
               end
            end
            ST_VERIFY: begin
               if (match_s) begin
                  exp_d  = step_exp_s;
                  good_d = good_inc_s;
                  if (good_inc_s == GW'(LOCK_CNT)) begin
                     state_d = ST_LOCKED;
                     bad_d   = {BW{1'b0}};
                  end else begin
                     state_d = ST_VERIFY;
                  end
               end else if (!zero_s) begin
                  // Wrong but usable word: treat it as a fresh seed.
                  exp_d   = step_data_s;
                  good_d  = {GW{1'b0}};
                  state_d = ST_VERIFY;
               end else begin
                  state_d = ST_HUNT;
               end
            end
            ST_LOCKED: begin
               // Flywheel: the prediction advances even on a bad word so a
               // single corrupted word does not knock us out of step.
               exp_d = step_exp_s;
               if (match_s) begin
                  bad_d = {BW{1'b0}};
               end else begin
                  err_pulse_d = 1'b1;
                  err_inc_s   = 1'b1;
                  bad_d       = bad_inc_s;
                  if (bad_inc_s == BW'(LOSS_CNT)) begin
                     state_d = ST_HUNT;
                  end else begin
                     state_d = ST_LOCKED;
                  end
               end
            end
            default: begin
               state_d = ST_HUNT;
               exp_d   = {n{1'b0}};
               good_d  = {GW{1'b0}};
               bad_d   = {BW{1'b0}};
            end
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // Error counter: clear beats increment; increment saturates at all-ones.
   always_comb begin
      if (clr_cnt) begin
         err_cnt_d = {CW{1'b0}};
      end else if (err_inc_s && (err_cnt_q != {CW{1'b1}})) begin
         err_cnt_d = err_cnt_q + CW'(1);
      end else begin
         err_cnt_d = err_cnt_q;
      end
      locked_d = (state_d == ST_LOCKED);
   end

   // State and output registers, asynchronously cleared.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_HUNT;
         exp_q       <= {n{1'b0}};
         good_q      <= {GW{1'b0}};
         bad_q       <= {BW{1'b0}};
         err_cnt_q   <= {CW{1'b0}};
         err_pulse_q <= 1'b0;
         locked_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         exp_q       <= exp_d;
         good_q      <= good_d;
         bad_q       <= bad_d;
         err_cnt_q   <= err_cnt_d;
         err_pulse_q <= err_pulse_d;
         locked_q    <= locked_d;
      end
   end

   assign locked    = locked_q;
   assign err_pulse = err_pulse_q;
   assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// -----------------------------------------------------------------------------
// tb_lfsr_checker
// Directed bench for lfsr_checker (n=4, TAPS=1001, CW=4 so saturation is
// reachable). Expected values are hand-derived from the x^4+x+1 sequence.
// -----------------------------------------------------------------------------
module tb_lfsr_checker;
   import lfsr_pkg::*;

   localparam int N  = 4;
   localparam int CW = 4;

   // x^4+x+1 sequence starting from 0001, hand-derived.
   localparam logic [3:0] SEQ [15] = '{
      4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1101, 4'b1010, 4'b0101,
      4'b1011, 4'b0110, 4'b1100, 4'b1001, 4'b0010, 4'b0100, 4'b1000
   };

   logic          clk = 1'b0;
   logic          rst;
   logic          ena;
   logic [N-1:0]  data_in;
   logic          clr_cnt;
   logic          locked;
   logic          err_pulse;
   logic [CW-1:0] err_cnt;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   lfsr_checker #(
      .n(N), .TAPS(4'b1001), .LOCK_CNT(4), .LOSS_CNT(3), .CW(CW)
   ) dut (
      .clk(clk), .rst(rst), .ena(ena), .data_in(data_in), .clr_cnt(clr_cnt),
      .locked(locked), .err_pulse(err_pulse), .err_cnt(err_cnt)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got === want) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", tag, got, want);
      end
   endtask

   task automatic drive(input logic e, input logic [3:0] d, input logic c);
      ena     = e;
      data_in = d;
      clr_cnt = c;
      @(posedge clk);
      #1;
      ena     = 1'b0;
      clr_cnt = 1'b0;
   endtask

   task automatic outs(input string tag, input logic lk, input logic ep, input logic [3:0] ec);
      check({tag, ".locked"},    {31'd0, locked},    {31'd0, lk});
      check({tag, ".err_pulse"}, {31'd0, err_pulse}, {31'd0, ep});
      check({tag, ".err_cnt"},   {28'd0, err_cnt},   {28'd0, ec});
   endtask

   initial begin
      int idx;
      int want;
      logic [3:0] gap_words [6];
      gap_words = '{4'b1101, 4'b1010, 4'b0101, 4'b1011, 4'b0110, 4'b1100};

      rst = 1'b1; ena = 1'b0; data_in = 4'b0000; clr_cnt = 1'b0;
      #12;
      outs("reset", 1'b0, 1'b0, 4'd0);
      check("reset.state", {30'd0, dut.state_q}, {30'd0, ST_HUNT});
      rst = 1'b0;
      @(posedge clk); #1;

      // Zero words never seed.
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 4'b0000, 1'b0);
         check("zero.state", {30'd0, dut.state_q}, {30'd0, ST_HUNT});
      end
      drive(1'b1, 4'b0001, 1'b0);
      check("seed.state", {30'd0, dut.state_q}, {30'd0, ST_VERIFY});
      check("seed.exp",   {28'd0, dut.exp_q},   32'h3);

      // Lock acquisition.
      drive(1'b1, 4'b0011, 1'b0); outs("acq1", 1'b0, 1'b0, 4'd0);
      drive(1'b1, 4'b0111, 1'b0); outs("acq2", 1'b0, 1'b0, 4'd0);
      drive(1'b1, 4'b1111, 1'b0); outs("acq3", 1'b0, 1'b0, 4'd0);
      drive(1'b1, 4'b1110, 1'b0); outs("acq4", 1'b1, 1'b0, 4'd0);

      // Single error, flywheel keeps the sequence aligned.
      drive(1'b1, 4'b1111, 1'b0); outs("err1", 1'b1, 1'b1, 4'd1);
      drive(1'b1, 4'b1010, 1'b0); outs("resume1", 1'b1, 1'b0, 4'd1);
      drive(1'b1, 4'b0101, 1'b0); outs("resume2", 1'b1, 1'b0, 4'd1);
      drive(1'b1, 4'b1011, 1'b0); outs("resume3", 1'b1, 1'b0, 4'd1);

      // Loss of lock after three consecutive bad words.
      drive(1'b1, 4'b0000, 1'b0); outs("loss1", 1'b1, 1'b1, 4'd2);
      drive(1'b1, 4'b0000, 1'b0); outs("loss2", 1'b1, 1'b1, 4'd3);
      drive(1'b1, 4'b0000, 1'b0); outs("loss3", 1'b0, 1'b1, 4'd4);
      check("loss.state", {30'd0, dut.state_q}, {30'd0, ST_HUNT});

      // Relock from a fresh seed.
      drive(1'b1, 4'b1000, 1'b0);
      check("reseed.exp", {28'd0, dut.exp_q}, 32'h1);
      drive(1'b1, 4'b0001, 1'b0); outs("relock1", 1'b0, 1'b0, 4'd4);
      drive(1'b1, 4'b0011, 1'b0); outs("relock2", 1'b0, 1'b0, 4'd4);
      drive(1'b1, 4'b0111, 1'b0); outs("relock3", 1'b0, 1'b0, 4'd4);
      drive(1'b1, 4'b1111, 1'b0); outs("relock4", 1'b1, 1'b0, 4'd4);

      // Plain clear on a matching word.
      drive(1'b1, 4'b1110, 1'b1); outs("clr", 1'b1, 1'b0, 4'd0);

      // Random ena gaps with garbage on data_in while ena=0.
      for (int i = 0; i < 6; i++) begin
         repeat ($urandom_range(0, 2)) begin
            drive(1'b0, 4'b0000, 1'b0);
            outs("gap.idle", 1'b1, 1'b0, 4'd0);
         end
         drive(1'b1, gap_words[i], 1'b0);
         outs("gap.word", 1'b1, 1'b0, 4'd0);
      end

      // Clear coinciding with a mismatch; pulse drops on an idle cycle.
      drive(1'b1, 4'b0000, 1'b1); outs("clr_err", 1'b1, 1'b1, 4'd0);
      drive(1'b0, 4'b0000, 1'b0); outs("clr_idle", 1'b1, 1'b0, 4'd0);
      drive(1'b1, 4'b0010, 1'b0); outs("clr_next", 1'b1, 1'b0, 4'd0);

      // A match between mismatches resets the loss count.
      drive(1'b1, 4'b1111, 1'b0); outs("bad1", 1'b1, 1'b1, 4'd1);
      drive(1'b1, 4'b1111, 1'b0); outs("bad2", 1'b1, 1'b1, 4'd2);
      drive(1'b1, 4'b0001, 1'b0); outs("badok", 1'b1, 1'b0, 4'd2);
      drive(1'b1, 4'b1111, 1'b0); outs("bad3", 1'b1, 1'b1, 4'd3);
      drive(1'b1, 4'b0111, 1'b0); outs("badok2", 1'b1, 1'b0, 4'd3);

      // Twenty isolated errors: counter saturates at 15.
      idx = 3;
      for (int k = 1; k <= 20; k++) begin
         drive(1'b1, 4'b0000, 1'b0);
         idx  = (idx + 1) % 15;
         want = (3 + k > 15) ? 15 : 3 + k;
         outs("sat.err", 1'b1, 1'b1, want[3:0]);
         if (k < 20) begin
            drive(1'b1, SEQ[idx], 1'b0);
            idx = (idx + 1) % 15;
            outs("sat.ok", 1'b1, 1'b0, want[3:0]);
         end
      end

      // Async reset between edges clears outputs before the next edge.
      #3;
      rst = 1'b1;
      #1;
      outs("async_rst", 1'b0, 1'b0, 4'd0);
      check("async_rst.state", {30'd0, dut.state_q}, {30'd0, ST_HUNT});
      #1;
      rst = 1'b0;
      drive(1'b1, 4'b0011, 1'b0);
      check("post_rst.state", {30'd0, dut.state_q}, {30'd0, ST_VERIFY});
      check("post_rst.exp",   {28'd0, dut.exp_q},   32'h7);
      outs("post_rst", 1'b0, 1'b0, 4'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
